key_schedule_gen: RTL and testbench

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

---
 rtl/key_schedule_gen_pkg.sv | 31 +++
 rtl/key_schedule_gen_aes_sbox.sv | 29 ++
 rtl/key_schedule_gen.sv | 112 +++++++++++
 tb/tb_key_schedule_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_gen_pkg.sv
// Shared types and constants for the AES-128 key expansion block.
package key_schedule_gen_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned NUM_WORDS = 44;
    localparam int unsigned KS_WIDTH  = 1408;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Round constants for rounds 1..10; RCON[9] is round 1.
    localparam logic [9:0][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[4'(4'd10 - idx)];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_schedule_gen_aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset is (255 - data) * 8.
    assign subst = SBOX[{~data, 3'b000} +: 8];

endmodule

// File: rtl/key_schedule_gen.sv
// AES-128 key expansion: one word per cycle into a registered 11-round-key schedule.
module key_schedule_gen
    import key_schedule_gen_pkg::*;
(
    input  logic                clk,
    input  logic                RESET_n,
    input  logic                start,
    input  logic [KEY_W-1:0]    key,
    output logic [KS_WIDTH-1:0] keyschedule,
    output logic                busy,
    output logic                done,
    output logic                key_valid
);

    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(4);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_WORDS - 1);

    state_t                      state, state_d;
    logic [CNT_W-1:0]            cnt;
    logic [3:0][WORD_W-1:0]      win;       // win[3] = w[i-4] ... win[0] = w[i-1]
    logic                        armed;
    logic                        load, step;
    logic [WORD_W-1:0]           rot, sub, word_new;
    logic [10:0]                 ks_base;

    // Next-state decode; load/step strobe the datapath.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    state_d = EXPAND;
                    load    = 1'b1;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rot = {win[0][23:0], win[0][31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data  (rot[8*b +: 8]),
            .subst (sub[8*b +: 8])
        );
    end

    always_comb begin
        if (cnt[1:0] == 2'b00) begin
            word_new = win[3] ^ sub ^ {rcon_byte(cnt[5:2]), 24'h000000};
        end else begin
            word_new = win[3] ^ win[0];
        end
        ks_base = 11'(KS_WIDTH) - {cnt, 5'b00000} - 11'd32;
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= IDLE;
            cnt         <= '0;
            win         <= '0;
            armed       <= 1'b0;
            keyschedule <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == EXPAND);
            done  <= (state_d == DONE);

            // A new request needs start seen low while idle.
            if (load) begin
                armed <= 1'b0;
            end else if (state == IDLE && !start) begin
                armed <= 1'b1;
            end

            if (load) begin
                win                             <= key;
                cnt                             <= FIRST_CNT;
                key_valid                       <= 1'b0;
                keyschedule[KS_WIDTH-1 -: KEY_W] <= key;
            end

            if (step) begin
                win                          <= {win[2:0], word_new};
                keyschedule[ks_base +: WORD_W] <= word_new;
                if (cnt != LAST_CNT) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen using FIPS-197 and all-zero key vectors.
module tb_key_schedule_gen;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic            clk = 1'b0;
    logic            RESET_n;
    logic            start;
    logic [127:0]    key;
    logic [1407:0]   keyschedule;
    logic            busy;
    logic            done;
    logic            key_valid;

    int checks = 0;
    int passes = 0;

    key_schedule_gen dut (
        .clk         (clk),
        .RESET_n     (RESET_n),
        .start       (start),
        .key         (key),
        .keyschedule (keyschedule),
        .busy        (busy),
        .done        (done),
        .key_valid   (key_valid)
    );

    always #5 clk = ~clk;

    // Runs one expansion; cycle 1 is the start-sampling edge. Returns the done cycle.
    task automatic run_expansion(input logic [127:0] k, input bit hold, input int poke_cyc,
                                 output int done_cyc, output int busy_bad, output int valid_bad);
        start = 1'b0;
        repeat (3) @(negedge clk);
        key       = k;
        start     = 1'b1;
        done_cyc  = -1;
        busy_bad  = 0;
        valid_bad = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1 && !hold) start = 1'b0;
            if (cyc == poke_cyc) begin
                key   = '1;
                start = 1'b1;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (key_valid !== 1'b0) valid_bad++;
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b1;
        start   = 1'b0;
        key     = '0;
        #2 RESET_n = 1'b0;
        #1;
        checks++;
        if (keyschedule !== '0) $display("FAIL reset_ks: keyschedule not zero, top %h", keyschedule[1407:1280]);
        else passes++;
        checks++;
        if ({busy, done, key_valid} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, key_valid});
        else passes++;
        @(negedge clk);
        #2 RESET_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, key_valid} !== 3'b000) $display("FAIL reset_idle: got %b want 000", {busy, done, key_valid});
        else passes++;
    endtask

    task automatic test_fips();
        int dc, bb, vb;
        run_expansion(FIPS_KEY, 1'b0, -5, dc, bb, vb);
        checks++;
        if (dc !== 41) $display("FAIL fips_done_cycle: got %0d want 41", dc);
        else passes++;
        checks++;
        if (bb !== 0) $display("FAIL fips_busy: busy low in %0d expand cycles, want 0", bb);
        else passes++;
        checks++;
        if (vb !== 0) $display("FAIL fips_valid_clear: key_valid high in %0d expand cycles, want 0", vb);
        else passes++;
        checks++;
        if (keyschedule[1279:1248] !== 32'ha0fafe17) $display("FAIL fips_w4: got %h want a0fafe17", keyschedule[1279:1248]);
        else passes++;
        checks++;
        if (keyschedule[1279:1152] !== FIPS_RK1) $display("FAIL fips_rk1: got %h want %h", keyschedule[1279:1152], FIPS_RK1);
        else passes++;
        checks++;
        if (keyschedule[127:0] !== FIPS_RK10) $display("FAIL fips_rk10: got %h want %h", keyschedule[127:0], FIPS_RK10);
        else passes++;
        checks++;
        if (keyschedule[1407:1280] !== FIPS_KEY) $display("FAIL fips_rk0: got %h want %h", keyschedule[1407:1280], FIPS_KEY);
        else passes++;
        checks++;
        if ({busy, key_valid} !== 2'b01) $display("FAIL fips_done_flags: busy,key_valid got %b want 01", {busy, key_valid});
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done, key_valid} !== 3'b001) $display("FAIL fips_back_idle: got %b want 001", {busy, done, key_valid});
        else passes++;
    endtask

    task automatic test_zero_key();
        int dc, bb, vb;
        run_expansion('0, 1'b0, -5, dc, bb, vb);
        checks++;
        if (dc !== 41) $display("FAIL zero_done_cycle: got %0d want 41", dc);
        else passes++;
        checks++;
        if (keyschedule[1279:1152] !== ZERO_RK1) $display("FAIL zero_rk1: got %h want %h", keyschedule[1279:1152], ZERO_RK1);
        else passes++;
        checks++;
        if (keyschedule[127:0] !== ZERO_RK10) $display("FAIL zero_rk10: got %h want %h", keyschedule[127:0], ZERO_RK10);
        else passes++;
        checks++;
        if (keyschedule[1407:1280] !== 128'h0) $display("FAIL zero_rk0: got %h want 0", keyschedule[1407:1280]);
        else passes++;
    endtask

    task automatic test_ignore_restart();
        int dc, bb, vb;
        run_expansion(FIPS_KEY, 1'b0, 10, dc, bb, vb);
        checks++;
        if (dc !== 41) $display("FAIL ign_done_cycle: got %0d want 41", dc);
        else passes++;
        checks++;
        if (bb !== 0) $display("FAIL ign_busy: busy low in %0d expand cycles, want 0", bb);
        else passes++;
        checks++;
        if (keyschedule[1279:1248] !== 32'ha0fafe17) $display("FAIL ign_w4: got %h want a0fafe17", keyschedule[1279:1248]);
        else passes++;
        checks++;
        if (keyschedule[127:0] !== FIPS_RK10) $display("FAIL ign_rk10: got %h want %h", keyschedule[127:0], FIPS_RK10);
        else passes++;
        checks++;
        if (keyschedule[1407:1280] !== FIPS_KEY) $display("FAIL ign_rk0: got %h want %h", keyschedule[1407:1280], FIPS_KEY);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL ign_no_restart: busy,done got %b want 00", {busy, done});
        else passes++;
    endtask

    task automatic test_abort();
        int dc, bb, vb;
        start = 1'b0;
        repeat (3) @(negedge clk);
        key   = FIPS_KEY;
        start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy);
        else passes++;
        #2 RESET_n = 1'b0;
        #1;
        checks++;
        if (keyschedule !== '0) $display("FAIL abort_ks_zero: top %h bottom %h want 0", keyschedule[1407:1280], keyschedule[127:0]);
        else passes++;
        checks++;
        if ({busy, done, key_valid} !== 3'b000) $display("FAIL abort_flags: got %b want 000", {busy, done, key_valid});
        else passes++;
        #1 RESET_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, done, key_valid} !== 3'b000) $display("FAIL abort_idle: got %b want 000", {busy, done, key_valid});
        else passes++;
        checks++;
        if (keyschedule !== '0) $display("FAIL abort_idle_ks: top %h want 0", keyschedule[1407:1280]);
        else passes++;
        run_expansion('0, 1'b0, -5, dc, bb, vb);
        checks++;
        if (dc !== 41) $display("FAIL abort_recover_cycle: got %0d want 41", dc);
        else passes++;
        checks++;
        if (keyschedule[127:0] !== ZERO_RK10) $display("FAIL abort_recover_rk10: got %h want %h", keyschedule[127:0], ZERO_RK10);
        else passes++;
    endtask

    task automatic test_hold_start();
        int dc, bb, vb;
        logic [1407:0] snap;
        run_expansion(FIPS_KEY, 1'b1, -5, dc, bb, vb);
        checks++;
        if (dc !== 41) $display("FAIL hold_done_cycle: got %0d want 41", dc);
        else passes++;
        snap = keyschedule;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({busy, done, key_valid} !== 3'b011) $display("FAIL hold_done_%0d: busy,done,key_valid got %b want 011", i, {busy, done, key_valid});
            else passes++;
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, key_valid} !== 3'b001) $display("FAIL hold_release: got %b want 001", {busy, done, key_valid});
        else passes++;
        checks++;
        if (keyschedule !== snap) $display("FAIL hold_ks_stable: rk10 got %h want %h", keyschedule[127:0], snap[127:0]);
        else passes++;
        checks++;
        if (keyschedule[1279:1152] !== FIPS_RK1) $display("FAIL hold_rk1: got %h want %h", keyschedule[1279:1152], FIPS_RK1);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, key_valid} !== 3'b001) $display("FAIL hold_stay_idle: got %b want 001", {busy, done, key_valid});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_ignore_restart();
        test_abort();
        test_hold_start();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
